// File: rtl/ctrl_sequencer.sv
// Hardwired T-state control sequencer for the 8-bit CPU.
// It steps through fetch, operand fetch and execute for each instruction.
// All strobes are Moore outputs, decoded from the state and the opcode latched in DC.
module ctrl_sequencer (
  input  logic        CLK,
  input  logic        CLRn,
  input  logic        RUN,
  input  logic [28:0] DEC,
  input  logic        ALU_DONE,
  output logic        IIRn,
  output logic        MAR_LDn,
  output logic        MAR_SRC,
  output logic        PC_INC,
  output logic        PC_LDn,
  output logic        MEM_RDn,
  output logic        MEM_WRn,
  output logic        A_LDn,
  output logic        B_LDn,
  output logic        A_OEn,
  output logic        ALU_OEn,
  output logic [2:0]  ALU_OP,
  output logic        ALU_SWAP,
  output logic        ALU_START,
  output logic        HALTED,
  output logic        ILLEGAL,
  output logic [3:0]  TSTATE
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_DC   = 4'd3,
    S_O0   = 4'd4,
    S_O1   = 4'd5,
    S_XLD  = 4'd6,
    S_XST  = 4'd7,
    S_XALU = 4'd8,
    S_MS   = 4'd9,
    S_MW   = 4'd10,
    S_HLT  = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic [28:0] op_q;
  logic        illegal_q;

  logic        dec_onehot, dec_ldst_jmp, dec_muldiv, dec_alu;
  logic [2:0]  alu_op_l;
  logic [3:0]  variant_l;
  logic        swap_l, dest_a_l;

  // Classify the live decoder lines for dispatch in DC
  always_comb begin
    dec_onehot   = (DEC != '0) && ((DEC & (DEC - 29'd1)) == '0);
    dec_ldst_jmp = (|DEC[1:0]) | DEC[26] | DEC[27];
    dec_muldiv   = |DEC[17:10];
    dec_alu      = (|DEC[9:2]) | (|DEC[25:18]);
  end

  // Decode ALU operation, operand order and destination from the latched opcode
  always_comb begin
    alu_op_l  = 3'd0;
    variant_l = '0;
    if      (|op_q[9:6])   alu_op_l = 3'd1;
    else if (|op_q[13:10]) alu_op_l = 3'd2;
    else if (|op_q[17:14]) alu_op_l = 3'd3;
    else if (|op_q[21:18]) alu_op_l = 3'd4;
    else if (|op_q[25:22]) alu_op_l = 3'd5;
    // Each ALU group is four adjacent lines in _A, _B, _AB, _BA order
    for (int unsigned g = 0; g < 6; g++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        variant_l[k] = variant_l[k] | op_q[2 + 4*g + k];
      end
    end
    swap_l   = variant_l[1] | variant_l[3];
    dest_a_l = variant_l[0] | variant_l[3];
  end

  // State, latched opcode and sticky illegal flag
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DC) begin
        op_q <= DEC;
        if (!dec_onehot) illegal_q <= 1'b1;
      end
    end
  end

  // Next-state logic; instruction boundaries return to F0 or IDLE depending on RUN
  always_comb begin
    state_t boundary;
    boundary = RUN ? S_F0 : S_IDLE;
    state_d  = state_q;
    case (state_q)
      S_IDLE: if (RUN) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_DC;
      S_DC: begin
        if (!dec_onehot)       state_d = boundary;
        else if (DEC[28])      state_d = S_HLT;
        else if (dec_muldiv)   state_d = S_MS;
        else if (dec_alu)      state_d = S_XALU;
        else if (dec_ldst_jmp) state_d = S_O0;
        else                   state_d = boundary;
      end
      S_O0:   state_d = S_O1;
      S_O1: begin
        if (op_q[27])      state_d = boundary;
        else if (op_q[26]) state_d = S_XST;
        else               state_d = S_XLD;
      end
      S_XLD, S_XST, S_XALU: state_d = boundary;
      S_MS:   state_d = S_MW;
      S_MW:   if (ALU_DONE) state_d = S_XALU;
      S_HLT:  state_d = S_HLT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    IIRn      = 1'b1;
    MAR_LDn   = 1'b1;
    MAR_SRC   = 1'b0;
    PC_INC    = 1'b0;
    PC_LDn    = 1'b1;
    MEM_RDn   = 1'b1;
    MEM_WRn   = 1'b1;
    A_LDn     = 1'b1;
    B_LDn     = 1'b1;
    A_OEn     = 1'b1;
    ALU_OEn   = 1'b1;
    ALU_OP    = 3'd0;
    ALU_SWAP  = 1'b0;
    ALU_START = 1'b0;
    case (state_q)
      S_F0, S_O0: MAR_LDn = 1'b0;
      S_F1: begin
        MEM_RDn = 1'b0;
        IIRn    = 1'b0;
        PC_INC  = 1'b1;
      end
      S_O1: begin
        MEM_RDn = 1'b0;
        if (op_q[27]) begin
          PC_LDn = 1'b0;
        end else begin
          PC_INC  = 1'b1;
          MAR_LDn = 1'b0;
          MAR_SRC = 1'b1;
        end
      end
      S_XLD: begin
        MEM_RDn = 1'b0;
        A_LDn   = ~op_q[0];
        B_LDn   = ~op_q[1];
      end
      S_XST: begin
        A_OEn   = 1'b0;
        MEM_WRn = 1'b0;
      end
      S_XALU: begin
        ALU_OEn  = 1'b0;
        ALU_OP   = alu_op_l;
        ALU_SWAP = swap_l;
        A_LDn    = ~dest_a_l;
        B_LDn    = dest_a_l;
      end
      S_MS: begin
        ALU_START = 1'b1;
        ALU_OP    = alu_op_l;
        ALU_SWAP  = swap_l;
      end
      S_MW: begin
        ALU_OP   = alu_op_l;
        ALU_SWAP = swap_l;
      end
      default: ;
    endcase
  end

  assign TSTATE  = state_q;
  assign ILLEGAL = illegal_q;
  // HLT is only ever entered with HALT as the latched opcode
  assign HALTED  = (state_q == S_HLT) & op_q[28];

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer.
// Each instruction is expanded by a reference model into its per-cycle list of expected strobes.
// Directed cases are followed by randomized instructions, with random noise on DEC/ALU_DONE/RUN where they are ignored.
module tb_ctrl_sequencer;

  logic        CLK = 1'b0;
  logic        CLRn, RUN, ALU_DONE;
  logic [28:0] DEC;
  logic        IIRn, MAR_LDn, MAR_SRC, PC_INC, PC_LDn, MEM_RDn, MEM_WRn;
  logic        A_LDn, B_LDn, A_OEn, ALU_OEn, ALU_SWAP, ALU_START, HALTED, ILLEGAL;
  logic [2:0]  ALU_OP;
  logic [3:0]  TSTATE;

  ctrl_sequencer dut (
    .CLK(CLK), .CLRn(CLRn), .RUN(RUN), .DEC(DEC), .ALU_DONE(ALU_DONE),
    .IIRn(IIRn), .MAR_LDn(MAR_LDn), .MAR_SRC(MAR_SRC), .PC_INC(PC_INC),
    .PC_LDn(PC_LDn), .MEM_RDn(MEM_RDn), .MEM_WRn(MEM_WRn), .A_LDn(A_LDn),
    .B_LDn(B_LDn), .A_OEn(A_OEn), .ALU_OEn(ALU_OEn), .ALU_OP(ALU_OP),
    .ALU_SWAP(ALU_SWAP), .ALU_START(ALU_START), .HALTED(HALTED),
    .ILLEGAL(ILLEGAL), .TSTATE(TSTATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] ts;
    logic iirn, mar_ldn, mar_src, pc_inc, pc_ldn, mem_rdn, mem_wrn;
    logic a_ldn, b_ldn, a_oen, alu_oen;
    logic [2:0] alu_op;
    logic swap, start, halted, illegal;
  } obs_t;

  int checks = 0;
  int failures = 0;
  bit ill_m = 1'b0;

  function automatic obs_t base(input logic [3:0] ts);
    obs_t o;
    o = '0;
    o.ts = ts;
    o.iirn = 1'b1; o.mar_ldn = 1'b1; o.pc_ldn = 1'b1; o.mem_rdn = 1'b1;
    o.mem_wrn = 1'b1; o.a_ldn = 1'b1; o.b_ldn = 1'b1; o.a_oen = 1'b1;
    o.alu_oen = 1'b1;
    o.illegal = ill_m;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{TSTATE, IIRn, MAR_LDn, MAR_SRC, PC_INC, PC_LDn, MEM_RDn, MEM_WRn,
          A_LDn, B_LDn, A_OEn, ALU_OEn, ALU_OP, ALU_SWAP, ALU_START, HALTED, ILLEGAL};
    return o;
  endfunction

  task automatic check(input obs_t exp, input string tag);
    obs_t got;
    got = sample();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle(input bit run);
    @(negedge CLK);
    RUN = run;
    DEC = 29'($urandom);
    ALU_DONE = 1'($urandom);
    check(base(4'd0), "idle");
  endtask

  task automatic do_reset_pulse(input string tag);
    #1 CLRn = 1'b0;
    ill_m = 1'b0;
    #1 check(base(4'd0), {tag, "_async"});
    @(posedge CLK);
    #1 check(base(4'd0), {tag, "_held"});
    #1 CLRn = 1'b1;
  endtask

  // Run one instruction from F0. n_mw: MW cycles until ALU_DONE (MUL/DIV only).
  // run_end: RUN at the boundary. abort_idx: cycle at which CLRn is pulsed (-1 = none).
  task automatic do_instr(input string name, input logic [28:0] dec, input int n_mw,
                          input bit run_end, input int abort_idx);
    obs_t q[$];
    bit   dn[$];
    obs_t o;
    int   idx, op, vr;
    bit   is_ill, is_halt;
    idx = 0;
    for (int i = 0; i < 29; i++) if (dec[i]) idx = i;
    is_ill  = ($countones(dec) != 1);
    is_halt = !is_ill && idx == 28;

    o = base(4'd1); o.mar_ldn = 1'b0; q.push_back(o); dn.push_back(1'b0);
    o = base(4'd2); o.mem_rdn = 1'b0; o.iirn = 1'b0; o.pc_inc = 1'b1;
    q.push_back(o); dn.push_back(1'b0);
    o = base(4'd3); q.push_back(o); dn.push_back(1'b0);
    if (is_ill) begin
      ill_m = 1'b1;
    end else if (is_halt) begin
      for (int k = 0; k < 20; k++) begin
        o = base(4'd11); o.halted = 1'b1; q.push_back(o); dn.push_back(1'b0);
      end
    end else if (idx <= 1 || idx >= 26) begin
      o = base(4'd4); o.mar_ldn = 1'b0; q.push_back(o); dn.push_back(1'b0);
      o = base(4'd5); o.mem_rdn = 1'b0;
      if (idx == 27) begin
        o.pc_ldn = 1'b0;
        q.push_back(o); dn.push_back(1'b0);
      end else begin
        o.pc_inc = 1'b1; o.mar_ldn = 1'b0; o.mar_src = 1'b1;
        q.push_back(o); dn.push_back(1'b0);
        if (idx == 26) begin
          o = base(4'd7); o.a_oen = 1'b0; o.mem_wrn = 1'b0;
        end else begin
          o = base(4'd6); o.mem_rdn = 1'b0;
          if (idx == 0) o.a_ldn = 1'b0; else o.b_ldn = 1'b0;
        end
        q.push_back(o); dn.push_back(1'b0);
      end
    end else begin
      op = (idx - 2) / 4;
      vr = (idx - 2) % 4;
      if (op == 2 || op == 3) begin
        o = base(4'd9); o.alu_op = 3'(op); o.swap = (vr == 1 || vr == 3); o.start = 1'b1;
        q.push_back(o); dn.push_back(1'b0);
        for (int k = 0; k < n_mw; k++) begin
          o = base(4'd10); o.alu_op = 3'(op); o.swap = (vr == 1 || vr == 3);
          q.push_back(o); dn.push_back(k == n_mw - 1);
        end
      end
      o = base(4'd8); o.alu_oen = 1'b0; o.alu_op = 3'(op); o.swap = (vr == 1 || vr == 3);
      if (vr == 0 || vr == 3) o.a_ldn = 1'b0; else o.b_ldn = 1'b0;
      q.push_back(o); dn.push_back(1'b0);
    end

    for (int i = 0; i < q.size(); i++) begin
      @(negedge CLK);
      DEC = (i == 2) ? dec : 29'($urandom);
      RUN = (i == q.size() - 1 && !is_halt) ? run_end : 1'($urandom);
      if (q[i].ts == 4'd10) ALU_DONE = dn[i];
      else if (i == 1)      ALU_DONE = 1'b1;
      else                  ALU_DONE = 1'($urandom);
      check(q[i], $sformatf("%s_c%0d", name, i));
      if (i == abort_idx) begin
        do_reset_pulse({name, "_abort"});
        return;
      end
    end
  endtask

  initial begin
    logic [28:0] d;
    int a, b;
    bit re;
    CLRn = 1'b0; RUN = 1'b0; DEC = '0; ALU_DONE = 1'b0;
    #1 check(base(4'd0), "reset");
    @(negedge CLK);
    check(base(4'd0), "reset_clk");
    CLRn = 1'b1;
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);

    do_instr("add_a", 29'd1 << 2, 0, 1'b1, -1);
    do_instr("ld_b", 29'd1 << 1, 0, 1'b1, -1);
    do_instr("st", 29'd1 << 26, 0, 1'b1, -1);
    do_instr("jmp", 29'd1 << 27, 0, 1'b1, -1);
    do_instr("mul_ba", 29'd1 << 13, 3, 1'b0, -1);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    do_instr("ill_zero", 29'd0, 0, 1'b1, -1);
    do_instr("ill_two", (29'd1 << 0) | (29'd1 << 26), 0, 1'b1, -1);
    do_instr("add_b", 29'd1 << 3, 0, 1'b1, -1);
    do_instr("ld_a", 29'd1 << 0, 0, 1'b1, -1);
    do_instr("div_ab", 29'd1 << 16, 1, 1'b1, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom_range(0, 27);
        b = $urandom_range(0, 27);
        d = (29'd1 << a) | (29'd1 << b);
        if ($urandom_range(0, 1) == 0) d = '0;
      end else begin
        d = 29'd1 << $urandom_range(0, 27);
      end
      re = ($urandom_range(0, 3) != 0);
      do_instr("rnd", d, $urandom_range(1, 4), re, -1);
      if (!re) begin
        repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
        idle_cycle(1'b1);
      end
    end

    do_instr("st_abort", 29'd1 << 26, 0, 1'b1, 5);
    idle_cycle(1'b1);
    do_instr("mul_abort", 29'd1 << 10, 5, 1'b1, 5);
    idle_cycle(1'b1);
    do_instr("halt", 29'd1 << 28, 0, 1'b1, -1);
    @(negedge CLK);
    do_reset_pulse("halt_reset");
    idle_cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Microprogrammed-free hardwired control sequencer for the 8-bit CPU, sitting directly downstream of the instruction register/decoder. It consumes the decoder's one-hot instruction lines and, through a T-state machine, generates every bus and register strobe for fetch, operand fetch and execute. This includes driving the IR's own active-low load `IIRn`. It also handshakes with the multi-cycle MUL/DIV unit and enforces HALT.

## Interface
- No parameters.
- `CLK` in 1: system clock, all state changes on rising edge.
- `CLRn` in 1: asynchronous, active-low reset.
- `RUN` in 1: 1 = start/continue execution; sampled only in IDLE and at instruction boundaries.
- `DEC` in 29: one-hot decoder lines.
  - [0] LD_A, [1] LD_B.
  - [2..5] ADD_A/B/AB/BA, [6..9] SUB_*, [10..13] MUL_*, [14..17] DIV_*, [18..21] SHL_*, [22..25] SHR_*.
  - [26] ST, [27] JMP, [28] HALT.
- `ALU_DONE` in 1: MUL/DIV result valid; sampled only in state MW.
- `IIRn` out 1: IR load enable, active low.
- `MAR_LDn` out 1: MAR load, active low.
- `MAR_SRC` out 1: MAR source, 0 = PC, 1 = data bus.
- `PC_INC` out 1: PC increment.
- `PC_LDn` out 1: PC load from data bus, active low.
- `MEM_RDn` out 1: memory read, active low.
- `MEM_WRn` out 1: memory write, active low.
- `A_LDn` out 1: A register load, active low.
- `B_LDn` out 1: B register load, active low.
- `A_OEn` out 1: A onto data bus, active low.
- `ALU_OEn` out 1: ALU result onto bus, active low.
- `ALU_OP` out 3: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR.
- `ALU_SWAP` out 1: operand order, 0 = A op B, 1 = B op A.
- `ALU_START` out 1: one-cycle MUL/DIV start pulse.
- `HALTED` out 1: sticky halt flag.
- `ILLEGAL` out 1: sticky illegal-opcode flag.
- `TSTATE` out 4: current state code, for debug.

## Operation
- States and codes: IDLE 0, F0 1, F1 2, DC 3, O0 4, O1 5, XLD 6, XST 7, XALU 8, MS 9, MW 10, HLT 11.
- All outputs are Moore-decoded from state plus the opcode latched in DC; an internal 29-bit copy of DEC is captured in DC.
- **IDLE**: go to F0 if RUN = 1.
- **F0**: MAR_LDn = 0, MAR_SRC = 0. Next F1.
- **F1**: MEM_RDn = 0, IIRn = 0, PC_INC = 1. Next DC.
- **DC**: capture DEC and dispatch.
  - LD/ST/JMP go to O0.
  - ADD/SUB/SHL/SHR go to XALU.
  - MUL/DIV go to MS.
  - HALT goes to HLT.
  - Zero or more than one bit set: set ILLEGAL and treat as NOP (boundary).
- **O0**: MAR_LDn = 0, MAR_SRC = 0. Next O1.
- **O1**: MEM_RDn = 0, PC_INC = 1.
  - JMP: PC_LDn = 0, PC_INC forced 0; then boundary.
  - Otherwise: MAR_LDn = 0, MAR_SRC = 1; next XLD for LD, XST for ST.
- **XLD**: MEM_RDn = 0; A_LDn = 0 (LD_A) or B_LDn = 0 (LD_B). Then boundary.
- **XST**: A_OEn = 0, MEM_WRn = 0. Then boundary.
- **XALU**: ALU_OEn = 0 with ALU_OP, ALU_SWAP and destination load per the variant rules below. Then boundary.
- ALU variant rules:
  - `_A`: A <= A op B (SWAP = 0, A_LDn = 0).
  - `_B`: B <= B op A (SWAP = 1, B_LDn = 0).
  - `_AB`: B <= A op B (SWAP = 0, B_LDn = 0).
  - `_BA`: A <= B op A (SWAP = 1, A_LDn = 0).
- **MS**: ALU_START = 1, ALU_OP/ALU_SWAP valid. Next MW.
- **MW**: ALU_OP/ALU_SWAP held. ALU_DONE = 1 goes to XALU; otherwise stay, with no timeout.
- **HLT**: HALTED = 1; stays until CLRn. RUN is ignored.
- **Boundary**: next state is F0 if RUN = 1, else IDLE.
- ALU_DONE outside MW is ignored.
- ILLEGAL stays set until reset and does not stop execution.

## Timing
- Reset (async, immediate on CLRn = 0):
  - State goes to IDLE.
  - All active-low outputs = 1.
  - PC_INC, MAR_SRC, ALU_OP, ALU_SWAP, ALU_START, HALTED, ILLEGAL = 0; TSTATE = 0.
- Reset mid-operation, including during MEM_WRn = 0 or MW, aborts immediately. There is no completion.
- Cycles per instruction from F0:
  - ALU ADD/SUB/SHL/SHR: 4.
  - JMP: 5.
  - LD/ST: 6.
  - MUL/DIV: 5 + N, where N ≥ 1 is the number of MW cycles up to and including the one where ALU_DONE = 1.
  - HALT: 3 to reach HLT.
- IIRn is low for exactly one cycle per instruction (F1). The decoder output is valid in DC.
- RUN dropping mid-instruction finishes that instruction, then goes to IDLE. Re-asserting RUN in IDLE enters F0 on the next edge.

## Test plan
- Reset then RUN = 1, DEC = bit 2 (ADD_A) in DC:
  - TSTATE sequence 0,1,2,3,8,1.
  - IIRn low only in state 2.
  - In state 8: ALU_OP = 0, ALU_SWAP = 0, A_LDn = 0, ALU_OEn = 0.
- LD_B then ST:
  - LD_B: O1 shows MAR_SRC = 1, MAR_LDn = 0, PC_INC = 1; XLD shows B_LDn = 0, MEM_RDn = 0. Total 6 cycles.
  - ST: XST shows A_OEn = 0, MEM_WRn = 0.
- JMP: O1 shows PC_LDn = 0, PC_INC = 0, MEM_RDn = 0; next state F0 after 5 cycles.
- MUL_BA with ALU_DONE raised on the 3rd MW cycle:
  - ALU_START high one cycle in MS.
  - ALU_OP = 2, ALU_SWAP = 1.
  - A_LDn = 0 in XALU; total 8 cycles.
  - A spurious ALU_DONE during F1 is ignored.
- Illegal opcodes:
  - DEC = 0 in DC: ILLEGAL = 1, next F0, no strobes.
  - DEC = bits 0|26: same.
  - ILLEGAL remains set after further valid instructions.
- HALT, then reset:
  - HALT: HALTED = 1, TSTATE = 11 held for 20 cycles regardless of RUN.
  - CLRn pulsed low mid-MW and during XST: outputs return to reset values asynchronously; MEM_WRn = 1 before the next edge.
